// File: rtl/ysyx_23060286_ifu.sv
// Instruction fetch unit: owns the PC and fetches one word per PC over an AXI4-Lite-style AR/R
// channel. Optional read timeout is enabled by defining YSYX_23060286_IFU_TIMEOUT_EN.
module ysyx_23060286_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_next,
    input  logic        pc_update,
    output logic [31:0] pc,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        fetch_err,
    output logic [1:0]  err_cause
);

    typedef enum logic [2:0] {
        StBoot,
        StAddr,
        StData,
        StValid,
        StExec,
        StErr
    } state_e;

    localparam logic [1:0] CauseNone     = 2'b00;
    localparam logic [1:0] CauseMisalign = 2'b01;
    localparam logic [1:0] CauseBus      = 2'b10;
    localparam logic [1:0] CauseTimeout  = 2'b11;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [1:0]  cause_q, cause_d;
    logic        arvalid_q, rready_q, inst_valid_q, fetch_err_q;
    logic        accept;

`ifdef YSYX_23060286_IFU_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

    logic [CntW-1:0] tmo_cnt_q;
    logic            tmo_hit;

    // Hit on the last waiting DATA cycle so ERR is entered after exactly TIMEOUT cycles.
    assign tmo_hit = (tmo_cnt_q == CntW'(TIMEOUT - 1));
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        cause_d = cause_q;
        accept  = 1'b0;

        case (state_q)
            StBoot: state_d = StAddr;
            StAddr: begin
                if (arready) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (rvalid) begin
                    if (rresp == 2'b00) begin
                        inst_d  = rdata;
                        state_d = StValid;
                    end else begin
                        cause_d = CauseBus;
                        state_d = StErr;
                    end
                end
`ifdef YSYX_23060286_IFU_TIMEOUT_EN
                else if (tmo_hit) begin
                    cause_d = CauseTimeout;
                    state_d = StErr;
                end
`endif
            end
            StValid: begin
                if (inst_ready) begin
                    if (pc_update) begin
                        accept = 1'b1;
                    end else begin
                        state_d = StExec;
                    end
                end
            end
            StExec: begin
                if (pc_update) begin
                    accept = 1'b1;
                end
            end
            StErr:   state_d = StErr;
            default: state_d = StBoot;
        endcase

        // A committed misaligned target is still loaded so the faulting PC is visible.
        if (accept) begin
            pc_d = pc_next;
            if (pc_next[1:0] != 2'b00) begin
                cause_d = CauseMisalign;
                state_d = StErr;
            end else begin
                state_d = StAddr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StBoot;
            pc_q         <= RESET_PC;
            inst_q       <= 32'h0;
            cause_q      <= CauseNone;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            inst_valid_q <= 1'b0;
            fetch_err_q  <= 1'b0;
`ifdef YSYX_23060286_IFU_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            cause_q      <= cause_d;
            arvalid_q    <= (state_d == StAddr);
            rready_q     <= (state_d == StData);
            inst_valid_q <= (state_d == StValid);
            fetch_err_q  <= (state_d == StErr);
`ifdef YSYX_23060286_IFU_TIMEOUT_EN
            if (state_q != StData) begin
                tmo_cnt_q <= '0;
            end else if (!rvalid) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
`endif
        end
    end

    assign pc         = pc_q;
    assign araddr     = pc_q;
    assign arvalid    = arvalid_q;
    assign rready     = rready_q;
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign fetch_err  = fetch_err_q;
    assign err_cause  = cause_q;

`ifndef SYNTHESIS
    a_timeout_cfg: assert property (@(posedge clk) TIMEOUT != 0);

    a_ar_hold: assert property (@(posedge clk) disable iff (!rst)
        arvalid && !arready |=> arvalid && $stable(araddr));

    a_out_onehot: assert property (@(posedge clk) disable iff (!rst)
        $onehot0({arvalid, rready, inst_valid, fetch_err}));

    a_err_sticky: assert property (@(posedge clk) disable iff (!rst)
        fetch_err |=> fetch_err && $stable(err_cause) && $stable(pc));
`endif

endmodule

// File: tb/tb_ysyx_23060286_ifu.sv
// Scoreboarded bench for ysyx_23060286_ifu: directed stimulus pushes expected AR addresses,
// accepted instructions and error causes; a negedge monitor pops and compares them.
module tb_ysyx_23060286_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_next;
    logic        pc_update;
    logic [31:0] pc;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic        fetch_err;
    logic [1:0]  err_cause;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_ar[$];
    logic [63:0] exp_inst[$];
    logic [1:0]  exp_err[$];
    logic [63:0] mon_e;
    logic        err_prev = 1'b0;

    ysyx_23060286_ifu #(
        .RESET_PC (32'h8000_0000),
        .TIMEOUT  (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_next    (pc_next),
        .pc_update  (pc_update),
        .pc         (pc),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .fetch_err  (fetch_err),
        .err_cause  (err_cause)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every handshake or error onset must match the head of its queue.
    always @(negedge clk) begin
        if (rst) begin
            if (arvalid && arready) begin
                if (exp_ar.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ar_unexpected: got %h expected none", araddr);
                end else begin
                    check("ar_addr", araddr, exp_ar.pop_front());
                end
            end
            if (inst_valid && inst_ready) begin
                if (exp_inst.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL inst_unexpected: got %h expected none", inst);
                end else begin
                    mon_e = exp_inst.pop_front();
                    check("inst_pc", pc, mon_e[63:32]);
                    check("inst_word", inst, mon_e[31:0]);
                end
            end
            if (fetch_err && !err_prev) begin
                if (exp_err.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL err_unexpected: got cause %0d expected none", err_cause);
                end else begin
                    check("err_cause", 32'(err_cause), 32'(exp_err.pop_front()));
                end
            end
        end
        err_prev <= fetch_err;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pc"}, pc, 32'h8000_0000);
        check({tag, "_araddr"}, araddr, 32'h8000_0000);
        check({tag, "_arvalid"}, 32'(arvalid), 0);
        check({tag, "_rready"}, 32'(rready), 0);
        check({tag, "_inst"}, inst, 0);
        check({tag, "_inst_valid"}, 32'(inst_valid), 0);
        check({tag, "_fetch_err"}, 32'(fetch_err), 0);
        check({tag, "_err_cause"}, 32'(err_cause), 0);
    endtask

    task automatic clear_inputs();
        arready    = 1'b0;
        rvalid     = 1'b0;
        rresp      = 2'b00;
        rdata      = 32'h0;
        inst_ready = 1'b0;
        pc_update  = 1'b0;
        pc_next    = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        #1 rst = 1'b0;
        #1 check_reset_vals("por");
        step();

        // First fetch with a zero-wait memory.
        arready = 1'b1;
        rvalid  = 1'b1;
        rdata   = 32'h0000_0413;
        exp_ar.push_back(32'h8000_0000);
        exp_inst.push_back({32'h8000_0000, 32'h0000_0413});
        rst = 1'b1;
        step();
        check("t1_arvalid", 32'(arvalid), 1);
        check("t1_araddr", araddr, 32'h8000_0000);
        step();
        check("t1_rready", 32'(rready), 1);
        check("t1_arvalid_drop", 32'(arvalid), 0);
        step();
        check("t1_inst_valid", 32'(inst_valid), 1);
        check("t1_inst", inst, 32'h0000_0413);
        arready = 1'b0;
        rvalid  = 1'b0;

        // Single-cycle consumer: accept and commit in the same cycle.
        inst_ready = 1'b1;
        pc_update  = 1'b1;
        pc_next    = 32'h8000_0004;
        step();
        check("t3_pc", pc, 32'h8000_0004);
        check("t3_arvalid", 32'(arvalid), 1);
        check("t3_inst_valid", 32'(inst_valid), 0);
        inst_ready = 1'b0;
        pc_update  = 1'b0;

        // AR stall.
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_stall_arvalid", 32'(arvalid), 1);
            check("t2_stall_araddr", araddr, 32'h8000_0004);
            check("t2_stall_rready", 32'(rready), 0);
        end
        arready = 1'b1;
        exp_ar.push_back(32'h8000_0004);
        step();
        check("t2_data_rready", 32'(rready), 1);
        check("t2_data_arvalid", 32'(arvalid), 0);
        arready = 1'b0;

        // Commit while in DATA must be ignored.
        pc_update = 1'b1;
        pc_next   = 32'h1234_5678;
        step();
        check("ign_data_pc", pc, 32'h8000_0004);
        check("ign_data_rready", 32'(rready), 1);
        pc_update = 1'b0;
        step();
        rvalid = 1'b1;
        rdata  = 32'h0010_0093;
        exp_inst.push_back({32'h8000_0004, 32'h0010_0093});
        step();
        check("t4_inst_valid", 32'(inst_valid), 1);
        check("t4_inst", inst, 32'h0010_0093);
        rvalid = 1'b0;

        // Commit in VALID without inst_ready is ignored.
        pc_update = 1'b1;
        pc_next   = 32'h8000_0010;
        step();
        check("ign_valid_pc", pc, 32'h8000_0004);
        check("ign_valid_iv", 32'(inst_valid), 1);
        pc_update  = 1'b0;
        inst_ready = 1'b1;
        step();
        check("exec_iv", 32'(inst_valid), 0);
        check("exec_inst", inst, 32'h0010_0093);
        inst_ready = 1'b0;
        step();
        check("exec_hold_arvalid", 32'(arvalid), 0);

        // Misaligned commit from EXEC.
        pc_update = 1'b1;
        pc_next   = 32'h8000_0006;
        exp_err.push_back(2'b01);
        step();
        check("mis_fetch_err", 32'(fetch_err), 1);
        check("mis_cause", 32'(err_cause), 1);
        check("mis_pc", pc, 32'h8000_0006);
        pc_next    = 32'h8000_0100;
        inst_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check("mis_sticky_arvalid", 32'(arvalid), 0);
            check("mis_sticky_err", 32'(fetch_err), 1);
        end
        check("mis_sticky_cause", 32'(err_cause), 1);
        check("mis_sticky_pc", pc, 32'h8000_0006);
        clear_inputs();

        // Bus error after a good fetch leaves inst untouched.
        rst = 1'b0;
        #1 check_reset_vals("rst2");
        step();
        arready = 1'b1;
        rvalid  = 1'b1;
        rdata   = 32'h0000_0413;
        exp_ar.push_back(32'h8000_0000);
        exp_inst.push_back({32'h8000_0000, 32'h0000_0413});
        rst = 1'b1;
        step();
        step();
        step();
        arready    = 1'b0;
        rvalid     = 1'b0;
        inst_ready = 1'b1;
        pc_update  = 1'b1;
        pc_next    = 32'h8000_0008;
        step();
        inst_ready = 1'b0;
        pc_update  = 1'b0;
        arready    = 1'b1;
        exp_ar.push_back(32'h8000_0008);
        step();
        arready = 1'b0;
        rvalid  = 1'b1;
        rresp   = 2'b10;
        rdata   = 32'hdead_beef;
        exp_err.push_back(2'b10);
        step();
        check("bus_fetch_err", 32'(fetch_err), 1);
        check("bus_cause", 32'(err_cause), 2);
        check("bus_inst", inst, 32'h0000_0413);
        check("bus_rready", 32'(rready), 0);
        clear_inputs();
        step();
        check("bus_sticky_cause", 32'(err_cause), 2);

        // Asynchronous reset in the middle of DATA.
        rst = 1'b0;
        step();
        arready = 1'b1;
        exp_ar.push_back(32'h8000_0000);
        rst = 1'b1;
        step();
        step();
        arready = 1'b0;
        check("mid_rready", 32'(rready), 1);
        #2 rst = 1'b0;
        #1 check_reset_vals("async");
        rvalid = 1'b1;
        rdata  = 32'hcafe_f00d;
        step();
        check("rst_rready", 32'(rready), 0);
        rst = 1'b1;
        step();
        check("post_rst_arvalid", 32'(arvalid), 1);
        check("post_rst_rready", 32'(rready), 0);
        step();
        check("post_rst_inst", inst, 0);
        check("post_rst_iv", 32'(inst_valid), 0);
        clear_inputs();

        // DATA with no response.
        rst = 1'b0;
        step();
        arready = 1'b1;
        exp_ar.push_back(32'h8000_0000);
`ifdef YSYX_23060286_IFU_TIMEOUT_EN
        exp_err.push_back(2'b11);
`endif
        rst = 1'b1;
        step();
        step();
        arready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
        end
        check("to_pre_rready", 32'(rready), 1);
        check("to_pre_err", 32'(fetch_err), 0);
`ifdef YSYX_23060286_IFU_TIMEOUT_EN
        step();
        check("to_err", 32'(fetch_err), 1);
        check("to_cause", 32'(err_cause), 3);
        check("to_rready", 32'(rready), 0);
`else
        for (int i = 0; i < 1000; i++) begin
            step();
        end
        check("noto_rready", 32'(rready), 1);
        check("noto_err", 32'(fetch_err), 0);
        check("noto_cause", 32'(err_cause), 0);
`endif

        step();
        check("sb_ar_left", 32'(exp_ar.size()), 0);
        check("sb_inst_left", 32'(exp_inst.size()), 0);
        check("sb_err_left", 32'(exp_err.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
